traffic_status_uart: RTL and testbench
======================================

// Module: traffic_status_uart
// PURPOSE
//   Downstream telemetry stage for the traffic controller top level. Watches the
//   6-bit lamp vector and the 16-bit completed-cycle count.
//   On any change it snapshots both values and serialises a 5-byte status frame
//   over a UART 8N1 line to the host/debug console.
//   Changes that arrive while a frame is in flight are coalesced into one
//   follow-up frame that carries the newest values.
// PARAMETERS
//   CLKS_PER_BIT   16     clk cycles per UART bit; legal range >= 2
//   SYNC_BYTE      8'hA5  first byte of every frame
// PORTS
//   clk          in   1   system clock; single clock domain
//   rst          in   1   reset: synchronous, active-low (sampled on posedge clk only)
//   led_state    in   6   lamp vector from the light driver
//   cycle_count  in   16  completed-cycle count from the cycle counter
//   tx_enable    in   1   1 = telemetry on; 0 = new change events ignored
//   uart_tx      out  1   serial line; idle high, LSB first, 8N1
//   busy         out  1   high from the first start bit to the last stop bit of a frame
//   frames_sent  out  8   completed-frame counter; wraps 255->0
// BEHAVIOUR
//   Reset (rst==0 at posedge)
//     - uart_tx=1, busy=0, frames_sent=0, pending=0, FSM=IDLE.
//     - prev_led and prev_cnt = 0.
//     - Bit/byte counters = 0.
//     - Reset mid-frame abandons the frame; uart_tx is high the cycle after.
//   Change detect
//     - change_evt = (led_state!=prev_led) | (cycle_count!=prev_cnt).
//     - prev_* is updated from the inputs on every non-reset edge.
//     - The first nonzero lamp value after reset therefore produces a frame.
//   Frame format
//     - B0 = SYNC_BYTE
//     - B1 = {2'b00, snap_led}
//     - B2 = snap_cnt[15:8]
//     - B3 = snap_cnt[7:0]
//     - B4 = B1^B2^B3
//     - Each byte is sent as: start(0), d0..d7, stop(1).
//     - Each bit is held exactly CLKS_PER_BIT cycles.
//     - A frame lasts 50*CLKS_PER_BIT cycles.
//   FSM states: IDLE -> START -> DATA -> STOP -> (next byte: START | frame end)
//     - IDLE: on an edge where change_evt & tx_enable:
//         - latch snap from the current inputs;
//         - go to START; uart_tx=0; busy=1.
//       The start bit is visible the cycle after the inputs change.
//     - START/DATA/STOP: bit counter counts 0..CLKS_PER_BIT-1, then advances.
//       DATA shifts out 8 bits, LSB first.
//     - Leaving STOP of B0..B3: go to START of the next byte (no idle gap).
//     - Leaving STOP of B4 (frame end): frames_sent += 1 (mod 256). Then:
//         - if pending | (change_evt & tx_enable): re-latch snap from the current
//           inputs, clear pending, go to START; busy stays 1; back-to-back frame.
//         - else: go to IDLE, busy=0, uart_tx=1.
//   Pending / coalescing
//     - change_evt & tx_enable while busy sets pending (1 bit).
//     - Any number of such changes yields exactly one extra frame.
//     - The extra frame carries the values present at the frame-end edge,
//       not those at the time of the change.
//     - tx_enable=0: new events neither start a frame nor set pending.
//       A frame in flight completes. An already-set pending is still honoured.
//   Snapshot stability
//     - snap_led and snap_cnt are frozen for the whole frame.
//     - Input changes never corrupt bytes already in flight.
//   Width rules
//     - All counters are unsigned.
//     - The bit counter is sized $clog2(CLKS_PER_BIT).
//     - frames_sent wraps silently, with no saturation.
// TESTING (CLKS_PER_BIT=4)
//   1. Reset:
//      - stimulus: hold rst=0 for 3 cycles with inputs toggling;
//      - required: uart_tx=1, busy=0, frames_sent=0 throughout.
//   2. Single frame:
//      - stimulus: led 0->6'b100001, count=16'h0003, tx_enable=1;
//      - required: bytes A5,21,00,03,22 decoded LSB-first; 200 cycles;
//        busy falls and frames_sent=1 at the end.
//   3. Coalescing:
//      - stimulus: 3 count changes (0004, 0005, 0006) during the first frame;
//      - required: exactly one back-to-back frame A5,21,00,06,27 with no idle
//        bit between frames; frames_sent=2; then IDLE.
//   4. Disable:
//      - stimulus: tx_enable=0, led changes;
//      - required: uart_tx stays 1, busy 0, frames_sent unchanged.
//        Re-enabling does not replay the old change.
//   5. Reset mid-frame:
//      - stimulus: rst=0 during a B2 data bit;
//      - required: uart_tx=1 and busy=0 the next cycle.
//        The next change yields a clean, correct full frame.
//   6. Wrap:
//      - stimulus: force 256 frames;
//      - required: frames_sent goes 255->0.
//        A change on the exact frame-end edge starts the next frame with no gap.

Source files
------------

// File: rtl/traffic_status_uart.sv
// Telemetry stage: snapshots lamp vector and cycle count on change and sends a
// 5-byte status frame (sync, led, cnt_hi, cnt_lo, xor) over a UART 8N1 line.
module traffic_status_uart #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  led_state,
  input  logic [15:0] cycle_count,
  input  logic        tx_enable,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  frames_sent
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_tick;
  logic [2:0]        r_bit_idx;
  logic [2:0]        r_byte_idx;
  logic [5:0]        r_prev_led;
  logic [15:0]       r_prev_cnt;
  logic [5:0]        r_snap_led;
  logic [15:0]       r_snap_cnt;
  logic              r_pending;
  logic              r_tx;
  logic              r_busy;
  logic [7:0]        r_frames;

  logic              w_fire;
  logic              w_tick_done;
  logic [7:0]        w_b1;
  logic [7:0]        w_byte;

  assign w_fire      = ((led_state != r_prev_led) | (cycle_count != r_prev_cnt)) & tx_enable;
  assign w_tick_done = (r_tick == LAST_TICK);
  assign w_b1        = {2'b00, r_snap_led};

  always_comb begin
    // NOTE: default assignment before the case keeps this purely combinational (no latch).
    w_byte = SYNC_BYTE;
    case (r_byte_idx)
      3'd1:    w_byte = w_b1;
      3'd2:    w_byte = r_snap_cnt[15:8];
      3'd3:    w_byte = r_snap_cnt[7:0];
      3'd4:    w_byte = w_b1 ^ r_snap_cnt[15:8] ^ r_snap_cnt[7:0];
      default: w_byte = SYNC_BYTE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_prev_led <= '0;
      r_prev_cnt <= '0;
      r_snap_led <= '0;
      r_snap_cnt <= '0;
      r_pending  <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_frames   <= '0;
    end else begin
      r_prev_led <= led_state;
      r_prev_cnt <= cycle_count;
      if (r_state != IDLE && w_fire) r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_snap_led <= led_state;
            r_snap_cnt <= cycle_count;
            r_tick     <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tick_done) begin
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_tx      <= w_byte[0];
            r_state   <= DATA;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        DATA: begin
          if (w_tick_done) begin
            r_tick <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= w_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        STOP: begin
          if (w_tick_done) begin
            r_tick <= '0;
            if (r_byte_idx != 3'd4) begin
              r_byte_idx <= r_byte_idx + 3'd1;
              r_tx       <= 1'b0;
              r_state    <= START;
            end else begin
              r_frames   <= r_frames + 8'd1;
              r_byte_idx <= '0;
              // Coalesced follow-up frame carries the values present right now.
              if (r_pending | w_fire) begin
                r_snap_led <= led_state;
                r_snap_cnt <= cycle_count;
                r_pending  <= 1'b0;
                r_tx       <= 1'b0;
                r_state    <= START;
              end else begin
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign uart_tx     = r_tx;
  assign busy        = r_busy;
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_traffic_status_uart.sv
// Bench for traffic_status_uart: a free-running UART receiver decodes the line
// and each scenario task compares decoded frames against frames built from the input values.
module tb_traffic_status_uart;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 50 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  led_state = '0;
  logic [15:0] cycle_count = '0;
  logic        tx_enable = 1'b1;
  logic        uart_tx;
  logic        busy;
  logic [7:0]  frames_sent;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [7:0]  exp_frames = '0;
  logic [7:0]  rx_q[$];
  int          rx_t[$];
  bit          mon_en = 1'b1;

  traffic_status_uart #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .led_state(led_state), .cycle_count(cycle_count),
    .tx_enable(tx_enable), .uart_tx(uart_tx), .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] frame_byte(input logic [5:0] led, input logic [15:0] cnt, input int k);
    logic [7:0] b1, hi, lo;
    b1 = {2'b00, led};
    hi = cnt[15:8];
    lo = cnt[7:0];
    case (k)
      0:       return 8'hA5;
      1:       return b1;
      2:       return hi;
      3:       return lo;
      default: return b1 ^ hi ^ lo;
    endcase
  endfunction

  // Line receiver: mid-bit sampling, abandons a byte if reset is seen.
  initial begin : monitor
    int         t0;
    logic [7:0] data;
    logic       stop_bit;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && rst === 1'b1) begin
        t0 = cyc;
        aborted = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        if (uart_tx !== 1'b0 || rst !== 1'b1) aborted = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          data[i] = uart_tx;
          if (rst !== 1'b1) aborted = 1'b1;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = uart_tx;
        if (rst !== 1'b1) aborted = 1'b1;
        if (!aborted && mon_en) begin
          total++;
          if (stop_bit !== 1'b1) begin
            bad++;
            $display("FAIL framing: stop bit=%b want 1 (byte start cycle %0d)", stop_bit, t0);
          end
          rx_q.push_back(data);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b still set after %0d cycles, want 0", name, busy, budget);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: tx=%b busy=%b frames=%0d want 1/0/0", i, uart_tx, busy, frames_sent);
      end
      led_state   = 6'($urandom);
      cycle_count = 16'($urandom);
    end
    @(negedge clk);
    led_state   = '0;
    cycle_count = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd0) begin
      bad++;
      $display("FAIL reset_release: tx=%b busy=%b frames=%0d want 1/0/0", uart_tx, busy, frames_sent);
    end
  endtask

  task automatic test_single_frame(input logic [5:0] led, input logic [15:0] cnt, input string name);
    logic [7:0] got;
    clear_rx();
    @(negedge clk);
    led_state   = led;
    cycle_count = cnt;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL %s_start: busy=%b tx=%b want 1/0", name, busy, uart_tx);
    end
    repeat (FRAME_CYC - 1) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_len: busy=%b one cycle before frame end, want 1", name, busy);
    end
    @(negedge clk);
    exp_frames = exp_frames + 8'd1;
    total++;
    if (busy !== 1'b0 || uart_tx !== 1'b1 || frames_sent !== exp_frames) begin
      bad++;
      $display("FAIL %s_end: busy=%b tx=%b frames=%0d want 0/1/%0d", name, busy, uart_tx, frames_sent, exp_frames);
    end
    total++;
    if (rx_q.size() != 5) begin
      bad++;
      $display("FAIL %s_count: got %0d bytes want 5", name, rx_q.size());
    end
    for (int k = 0; k < 5; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      total++;
      if (got !== frame_byte(led, cnt, k)) begin
        bad++;
        $display("FAIL %s_byte%0d: got %h want %h", name, k, got, frame_byte(led, cnt, k));
      end
    end
  endtask

  task automatic test_random_frames();
    logic [5:0]  led;
    logic [15:0] cnt;
    for (int n = 0; n < 4; n++) begin
      led = 6'($urandom);
      cnt = 16'($urandom);
      if (led == led_state && cnt == cycle_count) cnt = ~cnt;
      test_single_frame(led, cnt, $sformatf("rand%0d", n));
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end
  endtask

  task automatic test_coalescing();
    logic [7:0] exp_b[10];
    logic [7:0] got;
    for (int k = 0; k < 5; k++) begin
      exp_b[k]     = frame_byte(6'b100001, 16'h0004, k);
      exp_b[k + 5] = frame_byte(6'b100001, 16'h0006, k);
    end
    clear_rx();
    @(negedge clk);
    led_state   = 6'b100001;
    cycle_count = 16'h0004;
    @(negedge clk);
    repeat ($urandom_range(5, 40)) @(negedge clk);
    cycle_count = 16'h0005;
    repeat ($urandom_range(5, 40)) @(negedge clk);
    cycle_count = 16'h0006;
    wait_idle(2 * FRAME_CYC + 20, "coalesce");
    repeat (3 * CPB * 10) @(negedge clk);
    exp_frames = exp_frames + 8'd2;
    total++;
    if (frames_sent !== exp_frames || busy !== 1'b0) begin
      bad++;
      $display("FAIL coalesce_frames: frames=%0d busy=%b want %0d/0", frames_sent, busy, exp_frames);
    end
    total++;
    if (rx_q.size() != 10) begin
      bad++;
      $display("FAIL coalesce_count: got %0d bytes want 10", rx_q.size());
    end
    for (int k = 0; k < 10; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      total++;
      if (got !== exp_b[k]) begin
        bad++;
        $display("FAIL coalesce_byte%0d: got %h want %h", k, got, exp_b[k]);
      end
    end
    if (rx_t.size() >= 6) begin
      total++;
      if (rx_t[5] - rx_t[4] != 10 * CPB || rx_t[5] - rx_t[0] != FRAME_CYC) begin
        bad++;
        $display("FAIL coalesce_gap: byte spacing %0d frame spacing %0d want %0d/%0d",
                 rx_t[5] - rx_t[4], rx_t[5] - rx_t[0], 10 * CPB, FRAME_CYC);
      end
    end
  endtask

  task automatic test_disable();
    logic [7:0]  exp_b[10];
    logic [7:0]  got;
    logic [5:0]  led_a;
    logic [15:0] cnt_a;
    clear_rx();
    @(negedge clk);
    tx_enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0) led_state = led_state ^ 6'(1 + $urandom_range(0, 62));
      @(negedge clk);
      total++;
      if (uart_tx !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL disable_line[%0d]: tx=%b busy=%b want 1/0", i, uart_tx, busy);
      end
    end
    tx_enable = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (busy !== 1'b0 || frames_sent !== exp_frames || rx_q.size() != 0) begin
      bad++;
      $display("FAIL disable_replay: busy=%b frames=%0d bytes=%0d want 0/%0d/0", busy, frames_sent, rx_q.size(), exp_frames);
    end
    // Pending set while enabled must survive a later disable.
    led_a = 6'($urandom);
    cnt_a = cycle_count + 16'd1;
    cycle_count = cnt_a;
    led_state   = led_a;
    for (int k = 0; k < 5; k++) exp_b[k] = frame_byte(led_a, cnt_a, k);
    repeat (10) @(negedge clk);
    led_state = ~led_a;
    repeat (10) @(negedge clk);
    tx_enable   = 1'b0;
    cycle_count = 16'($urandom);
    for (int k = 0; k < 5; k++) exp_b[k + 5] = frame_byte(~led_a, cycle_count, k);
    wait_idle(2 * FRAME_CYC + 20, "pending");
    repeat (10) @(negedge clk);
    exp_frames = exp_frames + 8'd2;
    total++;
    if (frames_sent !== exp_frames || rx_q.size() != 10) begin
      bad++;
      $display("FAIL pending_frames: frames=%0d bytes=%0d want %0d/10", frames_sent, rx_q.size(), exp_frames);
    end
    for (int k = 0; k < 10; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      total++;
      if (got !== exp_b[k]) begin
        bad++;
        $display("FAIL pending_byte%0d: got %h want %h", k, got, exp_b[k]);
      end
    end
    tx_enable = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0]  led;
    logic [15:0] cnt;
    logic [7:0]  got;
    clear_rx();
    @(negedge clk);
    cycle_count = cycle_count + 16'd7;
    @(negedge clk);
    repeat (22 * CPB) @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    total++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd0) begin
      bad++;
      $display("FAIL midreset: tx=%b busy=%b frames=%0d want 1/0/0", uart_tx, busy, frames_sent);
    end
    exp_frames = 8'd0;
    repeat (12 * CPB) @(negedge clk);
    led = 6'($urandom) | 6'd1;
    cnt = 16'($urandom);
    led_state   = led;
    cycle_count = cnt;
    clear_rx();
    mon_en = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL midreset_restart: busy=%b tx=%b want 1/0", busy, uart_tx);
    end
    wait_idle(FRAME_CYC + 10, "midreset");
    exp_frames = exp_frames + 8'd1;
    total++;
    if (frames_sent !== exp_frames || rx_q.size() != 5) begin
      bad++;
      $display("FAIL midreset_frames: frames=%0d bytes=%0d want %0d/5", frames_sent, rx_q.size(), exp_frames);
    end
    for (int k = 0; k < 5; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      total++;
      if (got !== frame_byte(led, cnt, k)) begin
        bad++;
        $display("FAIL midreset_byte%0d: got %h want %h", k, got, frame_byte(led, cnt, k));
      end
    end
  endtask

  task automatic test_wrap();
    bit          seen_wrap = 1'b0;
    int          last_chg = -1;
    logic [7:0]  prev;
    logic [7:0]  got;
    logic [5:0]  led1, led2;
    logic [15:0] cnt1, cnt2;
    logic [7:0]  exp_b[10];
    mon_en = 1'b0;
    for (int i = 0; i < 60000 && !seen_wrap; i++) begin
      @(negedge clk);
      if (frames_sent !== exp_frames) begin
        prev = exp_frames;
        exp_frames = exp_frames + 8'd1;
        total++;
        if (frames_sent !== exp_frames) begin
          bad++;
          $display("FAIL wrap_step: frames=%0d want %0d", frames_sent, exp_frames);
        end
        if (last_chg >= 0) begin
          total++;
          if (cyc - last_chg != FRAME_CYC) begin
            bad++;
            $display("FAIL wrap_spacing: %0d cycles between frames want %0d", cyc - last_chg, FRAME_CYC);
          end
        end
        last_chg = cyc;
        if (prev == 8'd255) seen_wrap = 1'b1;
      end
      if (!seen_wrap) cycle_count = cycle_count + 16'd1;
    end
    total++;
    if (!seen_wrap) begin
      bad++;
      $display("FAIL wrap_seen: frames=%0d, 255->0 never observed", frames_sent);
    end
    wait_idle(2 * FRAME_CYC + 20, "wrap");
    exp_frames = exp_frames + 8'd1;
    total++;
    if (frames_sent !== exp_frames) begin
      bad++;
      $display("FAIL wrap_tail: frames=%0d want %0d", frames_sent, exp_frames);
    end
    // Change arriving exactly on the frame-end edge.
    clear_rx();
    mon_en = 1'b1;
    led1 = 6'($urandom);
    cnt1 = cycle_count ^ 16'hBEEF;
    led2 = ~led1;
    cnt2 = cnt1 + 16'd1;
    for (int k = 0; k < 5; k++) begin
      exp_b[k]     = frame_byte(led1, cnt1, k);
      exp_b[k + 5] = frame_byte(led2, cnt2, k);
    end
    @(negedge clk);
    led_state   = led1;
    cycle_count = cnt1;
    @(negedge clk);
    repeat (FRAME_CYC - 1) @(negedge clk);
    led_state   = led2;
    cycle_count = cnt2;
    @(negedge clk);
    exp_frames = exp_frames + 8'd1;
    total++;
    if (busy !== 1'b1 || uart_tx !== 1'b0 || frames_sent !== exp_frames) begin
      bad++;
      $display("FAIL edge_restart: busy=%b tx=%b frames=%0d want 1/0/%0d", busy, uart_tx, frames_sent, exp_frames);
    end
    wait_idle(FRAME_CYC + 10, "edge");
    exp_frames = exp_frames + 8'd1;
    total++;
    if (frames_sent !== exp_frames || rx_q.size() != 10) begin
      bad++;
      $display("FAIL edge_frames: frames=%0d bytes=%0d want %0d/10", frames_sent, rx_q.size(), exp_frames);
    end
    for (int k = 0; k < 10; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      total++;
      if (got !== exp_b[k]) begin
        bad++;
        $display("FAIL edge_byte%0d: got %h want %h", k, got, exp_b[k]);
      end
    end
    if (rx_t.size() >= 6) begin
      total++;
      if (rx_t[5] - rx_t[0] != FRAME_CYC) begin
        bad++;
        $display("FAIL edge_gap: frame spacing %0d want %0d", rx_t[5] - rx_t[0], FRAME_CYC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame(6'b100001, 16'h0003, "single");
    test_coalescing();
    test_random_frames();
    test_disable();
    test_reset_mid_frame();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
